// File: rtl/filt_scratch_reader.sv
// Replays a filter held in the scratchpad num_windows times to the MAC datapath,
// using circular addressing and a 2-entry valid/ready output buffer.
module filt_scratch_reader #(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_DEPTH = 16,
    parameter int SCRATCH_WIDTH = 16,
    parameter int WIN_LEN       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_LEN-1:0]      filt_base,
    input  logic [ADDR_LEN-1:0]      filt_len,
    input  logic [WIN_LEN-1:0]       num_windows,
    input  logic [SCRATCH_WIDTH-1:0] filt_scratch_rdata,
    input  logic                     out_ready,
    output logic                     filt_scratch_ren,
    output logic [ADDR_LEN-1:0]      filt_scratch_raddr,
    output logic [SCRATCH_WIDTH-1:0] filt_out,
    output logic                     filt_valid,
    output logic                     filt_last,
    output logic                     busy,
    output logic                     done,
    output logic                     filt_release
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                     last;
        logic [SCRATCH_WIDTH-1:0] data;
    } entry_t;

    localparam logic [ADDR_LEN:0] DEPTH = (ADDR_LEN + 1)'(SCRATCH_DEPTH);

    state_t               state_q, state_d;
    logic [ADDR_LEN-1:0]  base_q, len_q, e_q;
    logic [WIN_LEN-1:0]   nw_q, w_q;
    logic                 inflight_q, inflight_last_q;
    entry_t               fifo_q [2];
    logic                 rd_ptr_q, wr_ptr_q;
    logic [1:0]           occ_q;

    logic                 run, pop, elem_last, win_last;
    logic [ADDR_LEN:0]    addr_sum;

    assign elem_last = (e_q == len_q - ADDR_LEN'(1));
    assign win_last  = (w_q == nw_q - WIN_LEN'(1));
    assign pop       = filt_valid && out_ready;

    // Issue only if the word would still have a FIFO slot when it lands.
    assign filt_scratch_ren = run &&
        (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

    always_comb begin
        addr_sum = {1'b0, base_q} + {1'b0, e_q};
        if (addr_sum >= DEPTH) begin
            filt_scratch_raddr = ADDR_LEN'(addr_sum - DEPTH);
        end else begin
            filt_scratch_raddr = addr_sum[ADDR_LEN-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is defaulted first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (filt_len == '0 || num_windows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (filt_scratch_ren && elem_last && win_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q && occ_q == {1'b0, pop}) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        run          = (state_q == RUN);
        done         = (state_q == DONE);
        filt_release = (state_q == DONE);
    end

    // NOTE: the FIFO entries are reset too, because the head drives filt_out, which must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q          <= '0;
            len_q           <= '0;
            nw_q            <= '0;
            e_q             <= '0;
            w_q             <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_q[0]       <= '0;
            fifo_q[1]       <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            occ_q           <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                base_q <= filt_base;
                len_q  <= filt_len;
                nw_q   <= num_windows;
                e_q    <= '0;
                w_q    <= '0;
            end else if (filt_scratch_ren) begin
                if (elem_last) begin
                    e_q <= '0;
                    w_q <= w_q + WIN_LEN'(1);
                end else begin
                    e_q <= e_q + ADDR_LEN'(1);
                end
            end

            // The last tag rides alongside the read so filt_last is never decoded from the counters.
            inflight_q      <= filt_scratch_ren;
            inflight_last_q <= filt_scratch_ren && elem_last;

            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= '{last: inflight_last_q, data: filt_scratch_rdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    assign filt_valid = (occ_q != '0);
    assign filt_out   = fifo_q[rd_ptr_q].data;
    assign filt_last  = fifo_q[rd_ptr_q].last;

endmodule
